// File: rtl/rvga_debugtrace_if.sv
// Decoded-instruction debug bus driven by the decoder and observed by trace logic.
interface rvga_debugbus_if;
  logic [6:0] opcode;
  logic [2:0] inst_type;
  logic [2:0] brop;
  logic [2:0] ldop;
  logic [1:0] strop;
  logic [3:0] artop;

  modport o (output opcode, output inst_type, output brop, output ldop, output strop, output artop);
  modport i (input opcode, input inst_type, input brop, input ldop, input strop, input artop);
endinterface

// File: rtl/rvga_debugtrace.sv
// Observation-only trace stage: snapshots decoded instructions into a FWFT FIFO
// and keeps saturating per-class instruction counters for a debug host.
module rvga_debugtrace #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TRACE_W = 22
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rvga_debugbus_if.i         dbg,
  input  logic               dbg_valid_i,
  input  logic               clear_i,
  output logic [TRACE_W-1:0] trace_data_o,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic               overflow_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic [CNT_W-1:0]   total_cnt_o,
  output logic [CNT_W-1:0]   ld_cnt_o,
  output logic [CNT_W-1:0]   st_cnt_o,
  output logic [CNT_W-1:0]   br_cnt_o,
  output logic [CNT_W-1:0]   jmp_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [TRACE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_q, drop_d, total_q, total_d;
  logic [CNT_W-1:0]   ld_q, ld_d, st_q, st_d, br_q, br_d, jmp_q, jmp_d;
  logic [TRACE_W-1:0] entry;
  logic               full, pop, push_ok, drop;
  logic               is_ld, is_st, is_br, is_jmp;

  // Host handshake: an entry leaves the FIFO on a rising edge where
  // trace_valid_o && trace_ready_i; valid never depends on ready or dbg_valid_i.
  assign trace_valid_o = (count_q != '0);
  assign trace_data_o  = mem_q[rd_ptr_q];
  assign full          = (count_q == FULL_CNT);
  assign pop           = trace_valid_o && trace_ready_i;
  assign push_ok       = dbg_valid_i && (!full || pop);
  assign drop          = dbg_valid_i && full && !pop;

  assign entry  = {dbg.opcode, dbg.inst_type, dbg.brop, dbg.ldop, dbg.strop, dbg.artop};
  assign is_ld  = (dbg.opcode == OP_LOAD);
  assign is_st  = (dbg.opcode == OP_STORE);
  assign is_br  = (dbg.opcode == OP_BRANCH);
  assign is_jmp = (dbg.opcode == OP_JAL) || (dbg.opcode == OP_JALR);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    total_d    = total_q;
    ld_d       = ld_q;
    st_d       = st_q;
    br_d       = br_q;
    jmp_d      = jmp_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
      total_d    = '0;
      ld_d       = '0;
      st_d       = '0;
      br_d       = '0;
      jmp_d      = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      // Dropped requests are still classified; only storage is skipped.
      overflow_d = overflow_q | drop;
      drop_d     = sat_inc(drop_q, drop);
      total_d    = sat_inc(total_q, dbg_valid_i);
      ld_d       = sat_inc(ld_q, dbg_valid_i && is_ld);
      st_d       = sat_inc(st_q, dbg_valid_i && is_st);
      br_d       = sat_inc(br_q, dbg_valid_i && is_br);
      jmp_d      = sat_inc(jmp_q, dbg_valid_i && is_jmp);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      total_q    <= '0;
      ld_q       <= '0;
      st_q       <= '0;
      br_q       <= '0;
      jmp_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      total_q    <= total_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      br_q       <= br_d;
      jmp_q      <= jmp_d;
    end
  end

  // Storage carries no reset; stale entries are masked by trace_valid_o.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= entry;
  end

  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_q;
  assign total_cnt_o = total_q;
  assign ld_cnt_o    = ld_q;
  assign st_cnt_o    = st_q;
  assign br_cnt_o    = br_q;
  assign jmp_cnt_o   = jmp_q;
endmodule
